univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits, legal range 2..64.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port clear, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port mode, input, 2, operation select: 00 hold, 01 shift-up, 10 shift-down, 11 parallel load.
REQ-005 SHALL have port si, input, 1, serial data in.
REQ-006 SHALL have port d, input, WIDTH, parallel load data.
REQ-007 SHALL have port q, output, WIDTH, registered register contents.
REQ-008 SHALL have port so, output, 1, serial out; combinational mux of q.
REQ-009 SHALL have port word_valid, output, 1, registered one-cycle pulse marking a completed serial word.

Function
REQ-010 Hold (00): q, shift counter and direction register SHALL be unchanged.
REQ-011 Shift-up (01): q SHALL become {q[WIDTH-2:0], fill}.
REQ-012 Shift-down (10): q SHALL become {fill, q[WIDTH-1:1]}.
REQ-013 fill SHALL be si, except as modified by REQ-025.
REQ-014 Load (11): q SHALL become d; shift counter SHALL become 0; word_valid SHALL be 0 next cycle.
REQ-015 so SHALL be q[0] when mode=10, and q[WIDTH-1] for all other modes.
REQ-016 Shift counter range SHALL be 0..WIDTH-1, width $clog2(WIDTH); it SHALL increment on each shift in the same direction as the previous shift.
REQ-017 On the shift that takes the counter from WIDTH-1: counter SHALL wrap to 0, and word_valid SHALL be 1 for exactly the cycle following that edge, coincident with q holding the full word.
REQ-018 Direction change (first shift after a shift in the opposite direction): counter SHALL restart, the current shift counting as shift 1 (counter becomes 1).
REQ-019 The first shift after clear or load SHALL count as shift 1 in either direction.
REQ-020 Hold cycles SHALL NOT break a word; counting resumes on the next shift.
REQ-021 word_valid SHALL be 0 in any cycle not covered by REQ-017.

Reset
REQ-022 clear=1 at a rising edge SHALL set q=0, word_valid=0, shift counter=0, direction register to "none"; it SHALL override every mode.
REQ-023 clear asserted mid-word SHALL discard the partial count; a full WIDTH further shifts SHALL be required before word_valid.
REQ-024 Before the first clear, state is undefined; the bench SHALL apply clear in cycle 0.

Configuration
REQ-025 With macro USR_ROTATE_EN defined: input port rot (1 bit) SHALL exist; when rot=1 during a shift, fill SHALL be the bit shifted out (q[WIDTH-1] for up, q[0] for down) instead of si; counting and word_valid SHALL be unaffected. Without USR_ROTATE_EN: rot SHALL be absent and fill SHALL always be si.

Structure
REQ-026 Package usr_pkg SHALL hold the mode encodings (MODE_HOLD, MODE_UP, MODE_DOWN, MODE_LOAD) and the direction-register encodings (DIR_NONE, DIR_UP, DIR_DOWN).
REQ-027 Sub-module usr_cell SHALL implement one bit: a 4:1 next-state mux (hold, up-neighbour, down-neighbour, load) plus a flop with synchronous clear; it SHALL be instantiated WIDTH times via generate. Counter, direction register and word_valid logic SHALL live in univ_shift_reg.

Verification (WIDTH=8)
REQ-028 clear=1 for one edge with mode=11, d=0xFF -> q=0x00, word_valid=0, so=0.
REQ-029 mode=01, si=1,0,1,1,0,0,1,0 over 8 edges -> q=0xB2 after the 8th edge; word_valid=1 only in that following cycle.
REQ-030 load d=0xA5, then mode=10 with si=0 for 8 edges -> so before each edge = 1,0,1,0,0,1,0,1; final q=0x00; word_valid pulses once after the 8th edge.
REQ-031 3 up-shifts, 2 holds, 5 up-shifts -> word_valid pulses once after the 10th edge. Also: 3 up-shifts then 8 down-shifts -> word_valid only after the 8th down-shift.
REQ-032 5 up-shifts, then clear=1 with mode=01 -> q=0x00; a further 7 shifts give no word_valid; the 8th shift does.
REQ-033 USR_ROTATE_EN: load 0x81, rot=1, one up-shift -> q=0x03. Then rot=1 with one down-shift -> q=0x81.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register.
// Mode select values and the shift direction register.
package usr_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_e;

endpackage

// File: rtl/usr_cell.sv
// One register bit: hold / up / down / load mux
// feeding a flop with synchronous clear.
module usr_cell
    import usr_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic [1:0] sel,
    input  logic       up_in,
    input  logic       dn_in,
    input  logic       ld_in,
    output logic       q
);

    logic nxt;

    always_comb begin
        nxt = q;
        case (sel)
            MODE_UP:   nxt = up_in;
            MODE_DOWN: nxt = dn_in;
            MODE_LOAD: nxt = ld_in;
            default:   nxt = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) q <= 1'b0;
        else       q <= nxt;
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with serial word framing.
// Define USR_ROTATE_EN to add the rot input (rotate fill).
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [1:0]       mode,
    input  logic             si,
`ifdef USR_ROTATE_EN
    input  logic             rot,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             so,
    output logic             word_valid
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CMAX = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;
    dir_e          dir;
    dir_e          dir_now;
    logic          shift;
    logic          ld;
    logic          fill_up;
    logic          fill_dn;

`ifdef USR_ROTATE_EN
    assign fill_up = rot ? q[WIDTH-1] : si;
    assign fill_dn = rot ? q[0] : si;
`else
    assign fill_up = si;
    assign fill_dn = si;
`endif

    assign so = (mode == MODE_DOWN) ? q[0] : q[WIDTH-1];

    always_comb begin
        shift   = (mode == MODE_UP) || (mode == MODE_DOWN);
        ld      = (mode == MODE_LOAD);
        dir_now = (mode == MODE_DOWN) ? DIR_DOWN : DIR_UP;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic up_in;
        logic dn_in;

        if (i == 0) begin : g_lo
            assign up_in = fill_up;
        end else begin : g_lo
            assign up_in = q[i-1];
        end

        if (i == WIDTH - 1) begin : g_hi
            assign dn_in = fill_dn;
        end else begin : g_hi
            assign dn_in = q[i+1];
        end

        usr_cell u_cell (
            .clk   (clk),
            .clear (clear),
            .sel   (mode),
            .up_in (up_in),
            .dn_in (dn_in),
            .ld_in (d[i]),
            .q     (q[i])
        );
    end

    // A shift in a new direction (or the first after clear/load)
    // starts a fresh word and counts as shift 1.
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt        <= '0;
            dir        <= DIR_NONE;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            unique case (1'b1)
                ld: begin
                    cnt <= '0;
                    dir <= DIR_NONE;
                end
                shift: begin
                    dir <= dir_now;
                    if (dir != dir_now) begin
                        cnt <= CW'(1);
                    end else if (cnt == CMAX) begin
                        cnt        <= '0;
                        word_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg at WIDTH=8.
// Directed vectors; expected values are hand-derived.
module tb_univ_shift_reg;

    typedef struct {
        int         id;
        logic [7:0] q;
        logic       wv;
        logic       so;
        logic       cso;
    } exp_t;

    logic       clk;
    logic       clear;
    logic [1:0] mode;
    logic       si;
    logic       rot;
    logic [7:0] d;
    logic [7:0] q;
    logic       so;
    logic       word_valid;

    exp_t sb[$];
    int   ncmp;
    int   nbad;
    int   vid;

    univ_shift_reg #(.WIDTH(8)) dut (
        .clk        (clk),
        .clear      (clear),
        .mode       (mode),
        .si         (si),
`ifdef USR_ROTATE_EN
        .rot        (rot),
`endif
        .d          (d),
        .q          (q),
        .so         (so),
        .word_valid (word_valid)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Drive one edge worth of inputs and queue what must be seen:
    // so before the edge (when cso) and q/word_valid after it.
    task automatic step(input logic c, input logic [1:0] m,
                        input logic s, input logic [7:0] dd,
                        input logic r, input logic [7:0] eq,
                        input logic ewv, input logic cso,
                        input logic eso);
        exp_t e;
        @(negedge clk);
        clear = c;
        mode  = m;
        si    = s;
        d     = dd;
        rot   = r;
        vid++;
        e.id  = vid;
        e.q   = eq;
        e.wv  = ewv;
        e.so  = eso;
        e.cso = cso;
        sb.push_back(e);
    endtask

    task automatic shifts(input logic [1:0] m, input logic [7:0] bits,
                          input logic [7:0] qs[8], input int n,
                          input int wv_at);
        for (int i = 0; i < n; i++)
            step(1'b0, m, bits[i], 8'h00, 1'b0, qs[i],
                 (i == wv_at), 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.cso) begin
                    ncmp++;
                    if (so !== e.so) begin
                        nbad++;
                        $display("FAIL so vec %0d: got %b want %b",
                                 e.id, so, e.so);
                    end
                end
                @(posedge clk);
                #1;
                ncmp++;
                if (q !== e.q) begin
                    nbad++;
                    $display("FAIL q vec %0d: got %h want %h",
                             e.id, q, e.q);
                end
                ncmp++;
                if (word_valid !== e.wv) begin
                    nbad++;
                    $display("FAIL word_valid vec %0d: got %b want %b",
                             e.id, word_valid, e.wv);
                end
            end
        end
    end

    initial begin : driver
        logic [7:0] qs[8];
        logic [7:0] sov;
        int budget;
        ncmp  = 0;
        nbad  = 0;
        vid   = 0;
        clear = 1'b1;
        mode  = 2'b11;
        si    = 1'b0;
        d     = 8'hFF;
        rot   = 1'b0;

        // Clear overrides a load of 0xFF.
        step(1'b1, 2'b11, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Shift-up word 1,0,1,1,0,0,1,0 -> 0xB2.
        qs = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h59, 8'hB2};
        shifts(2'b01, 8'b0100_1101, qs, 8, 7);
        step(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 8'hB2, 1'b0, 1'b1, 1'b1);

        // Load 0xA5 then shift down with si=0, checking so each edge.
        step(1'b0, 2'b11, 1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
        qs  = '{8'h52, 8'h29, 8'h14, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};
        sov = 8'b1010_0101;
        for (int i = 0; i < 8; i++)
            step(1'b0, 2'b10, 1'b0, 8'h00, 1'b0, qs[i], (i == 7),
                 1'b1, sov[i]);
        step(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // 3 up, 2 holds, 5 up: word completes on the 10th edge.
        step(1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        qs = '{8'h01, 8'h03, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        shifts(2'b01, 8'b0000_0111, qs, 3, -1);
        step(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b1, 8'h00, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0);
        qs = '{8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'h00, 8'h00, 8'h00};
        shifts(2'b01, 8'b0000_0000, qs, 5, 4);
        step(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 8'hE0, 1'b0, 1'b0, 1'b0);

        // 3 up then 8 down: only the 8th down shift completes a word.
        step(1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        qs = '{8'h01, 8'h03, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        shifts(2'b01, 8'b0000_0111, qs, 3, -1);
        qs = '{8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        shifts(2'b10, 8'b0000_0000, qs, 8, 7);
        step(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Clear mid-word discards the partial count.
        step(1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        qs = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h00, 8'h00, 8'h00};
        shifts(2'b01, 8'b1111_1111, qs, 5, -1);
        step(1'b1, 2'b01, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        qs = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        shifts(2'b01, 8'b1111_1111, qs, 8, 7);
        step(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1);

`ifdef USR_ROTATE_EN
        // Rotate: fill comes from the bit shifted out.
        step(1'b0, 2'b11, 1'b0, 8'h81, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'b01, 1'b0, 8'h00, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1);
        step(1'b0, 2'b10, 1'b0, 8'h00, 1'b1, 8'h81, 1'b0, 1'b1, 1'b1);
`endif

        step(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, q, 1'b0, 1'b0, 1'b0);
        budget = 0;
        while (sb.size() != 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            ncmp++;
            nbad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nbad);
        $finish;
    end

endmodule
